// File: rtl/serial_adder_fsm_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_fsm_pkg
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width used by the interface and the top level.
// -----------------------------------------------------------------------------
package serial_adder_fsm_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_fsm_if.sv
// -----------------------------------------------------------------------------
// serial_adder_fsm_if
// Request/result bundle of the bit-serial adder.
//   start        request, sampled only while the adder is idle
//   a, b, cin    operands, captured on an accepted start
//   busy         high while an operation is in flight
//   done         one-cycle pulse when sum/cout are updated
//   sum, cout    registered result, held until the next done
// master: requester side; slave: the adder.
// -----------------------------------------------------------------------------
interface serial_adder_fsm_if
  import serial_adder_fsm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder_fsm_fa_2ha.sv
// -----------------------------------------------------------------------------
// fa_2ha
// Combinational full adder built from two half-adder cells; the two partial
// carries can never both be set, so a plain OR merges them.
//   a, b, ci   input bits
//   s, co      sum bit and carry-out
// ha_cell: single half adder (s = a ^ b, c = a & b).
// -----------------------------------------------------------------------------
module ha_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module fa_2ha (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  ha_cell u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  ha_cell u_ha1 (
    .a (s0),
    .b (ci),
    .s (s),
    .c (c1)
  );

  assign co = c0 | c1;

endmodule

// File: rtl/serial_adder_fsm.sv
// -----------------------------------------------------------------------------
// serial_adder_fsm
// Bit-serial WIDTH-bit adder, LSB first. An accepted start latches a, b and
// cin; WIDTH RUN cycles then each produce one sum bit through a single full
// adder; a final DONE cycle copies the result into the output registers and
// raises a one-cycle done pulse together with the new sum/cout.
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     request/result bundle (slave side), see serial_adder_fsm_if
// -----------------------------------------------------------------------------
module serial_adder_fsm
  import serial_adder_fsm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  serial_adder_fsm_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic             s_bit;
  logic             c_bit;

  fa_2ha u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (s_bit),
    .co (c_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Sum bits enter at the MSB so after WIDTH shifts bit 0 holds the LSB.
        s_sr_d  = {s_bit, s_sr_q[WIDTH-1:1]};
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d = c_bit;
        if (cnt_q == CNT_LAST) begin
          // Clear rather than wrap so the counter stays below WIDTH for any WIDTH.
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        // Result and pulse are registered on the same edge so they appear together.
        sum_d   = s_sr_q;
        cout_d  = carry_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
